flb_dlf: RTL and testbench

Digital loop filter and band tracker for the DPLL fine loop, in the `ref_clk` domain. It sits directly upstream of the FLB block:
- It converts the signed phase-error samples into the 16-bit `dlf_out` control word using a proportional-integral filter.
- It owns the 8-bit `band` word, stepping it when the integrator stays parked near either rail.

---
 rtl/flb_dlf.sv | 249 ++++++++++++++++++++++++
 tb/tb_flb_dlf.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flb_dlf.sv
// flb_dlf: proportional-integral loop filter plus band tracker for the DPLL fine loop.
// Stage 1 updates the 16.8 integrator and latches the proportional term. Stage 2
// forms the clamped 16-bit control word. The band tracker watches the integrator
// at each stage-2 edge and steps the band when it stays parked near a rail.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_TRACK   | rail counter follows the integrator, a band step may trigger
// ST_HOLDOFF | band step just taken, rail evaluation suppressed for a while
module flb_dlf #(
  parameter int HOLDOFF_CYC = 64,
  parameter int PHE_W       = 10
) (
  input  logic                    ref_clk,
  input  logic                    csr_dlf_rst,
  input  logic signed [PHE_W-1:0] phe,
  input  logic                    phe_vld,
  input  logic [2:0]              csr_dlf_kp_shift,
  input  logic [2:0]              csr_dlf_ki_shift,
  input  logic                    csr_dlf_freeze,
  input  logic                    csr_dlf_int_load,
  input  logic [15:0]             csr_dlf_int_init,
  input  logic [7:0]              csr_dlf_band_init,
  input  logic                    csr_dlf_bt_en,
  input  logic [3:0]              csr_dlf_bt_cnt,
  output logic [15:0]             dlf_out,
  output logic                    dlf_vld,
  output logic [7:0]              band,
  output logic                    band_inc,
  output logic                    band_dec,
  output logic                    sat_hi,
  output logic                    sat_lo,
  output logic                    band_lim
);

  localparam int              HW        = $clog2(HOLDOFF_CYC + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLDOFF_CYC - 1);
  localparam logic [23:0]     INT_MID   = 24'h800000;

  typedef enum logic {ST_TRACK, ST_HOLDOFF} state_t;
  typedef enum logic [1:0] {RAIL_NONE, RAIL_HI, RAIL_LO} rail_t;

  // stage 1
  logic [23:0]        int_acc_q, int_acc_d, int_clamped;
  logic signed [17:0] prop_q, prop_d, prop_shift;
  logic               s1_vld_q;
  logic signed [25:0] phe_ext, inc_val, acc_sum;

  // stage 2
  logic [15:0]        out_q, out_d;
  logic               vld_q, sat_hi_q, sat_lo_q, sat_hi_d, sat_lo_d;
  logic signed [18:0] out_sum;

  // band tracker
  state_t             state_q, state_d;
  rail_t              rail_q, rail_d;
  logic [3:0]         cnt_q, cnt_d, cnt_next;
  logic [HW-1:0]      hold_q, hold_d;
  logic [7:0]         band_q, band_d;
  logic               inc_q, inc_d, dec_q, dec_d, lim_q, lim_d;
  logic               reload;
  logic               rail_hi, rail_lo;

  // Integrator sum and proportional term; both clamped into their storage ranges.
  always_comb begin
    phe_ext    = 26'(phe);
    inc_val    = phe_ext <<< csr_dlf_ki_shift;
    acc_sum    = $signed({2'b00, int_acc_q}) + inc_val;
    prop_shift = 18'(phe) <<< csr_dlf_kp_shift;
    prop_d     = csr_dlf_freeze ? '0 : prop_shift;
    if (acc_sum[25]) begin
      int_clamped = 24'h000000;
    end else if (acc_sum[24]) begin
      int_clamped = 24'hFFFFFF;
    end else begin
      int_clamped = acc_sum[23:0];
    end
  end

  // Integrator next value: load beats band reload, which beats the filter update.
  always_comb begin
    int_acc_d = int_acc_q;
    if (csr_dlf_int_load) begin
      int_acc_d = {csr_dlf_int_init, 8'h00};
    end else if (reload) begin
      int_acc_d = INT_MID;
    end else if (phe_vld && !csr_dlf_freeze) begin
      int_acc_d = int_clamped;
    end
  end

  // Output word: integer part of the integrator plus proportional term, clamped.
  always_comb begin
    out_sum  = $signed({3'b000, int_acc_q[23:8]}) + 19'(prop_q);
    out_d    = out_sum[15:0];
    sat_hi_d = 1'b0;
    sat_lo_d = 1'b0;
    if (out_sum[18]) begin
      out_d    = 16'h0000;
      sat_lo_d = 1'b1;
    end else if (out_sum[17:16] != 2'b00) begin
      out_d    = 16'hFFFF;
      sat_hi_d = 1'b1;
    end
  end

  // Band tracker: rail run counting, step trigger and holdoff timing.
  always_comb begin
    state_d  = state_q;
    rail_d   = rail_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    band_d   = band_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    lim_d    = lim_q;
    reload   = 1'b0;
    rail_hi  = (int_acc_q[23:8] >= 16'hF000);
    rail_lo  = (int_acc_q[23:8] <= 16'h0FFF);
    cnt_next = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    if (csr_dlf_int_load) begin
      band_d  = csr_dlf_band_init;
      lim_d   = 1'b0;
      cnt_d   = '0;
      rail_d  = RAIL_NONE;
      hold_d  = '0;
      state_d = ST_TRACK;
    end else if (!csr_dlf_bt_en) begin
      cnt_d   = '0;
      rail_d  = RAIL_NONE;
      hold_d  = '0;
      state_d = ST_TRACK;
    end else begin
      case (state_q)
        ST_TRACK: begin
          if (s1_vld_q) begin
            if (rail_hi) begin
              cnt_d  = (rail_q == RAIL_HI) ? cnt_next : 4'd1;
              rail_d = RAIL_HI;
            end else if (rail_lo) begin
              cnt_d  = (rail_q == RAIL_LO) ? cnt_next : 4'd1;
              rail_d = RAIL_LO;
            end else begin
              cnt_d  = '0;
              rail_d = RAIL_NONE;
            end
            if ((rail_d != RAIL_NONE) && (csr_dlf_bt_cnt != 4'd0) && (cnt_d == csr_dlf_bt_cnt)) begin
              // at a band limit the integrator is left alone and only the flag is raised
              if (rail_d == RAIL_HI) begin
                if (band_q == 8'hFF) begin
                  lim_d = 1'b1;
                end else begin
                  band_d = band_q + 8'd1;
                  inc_d  = 1'b1;
                  reload = 1'b1;
                end
              end else begin
                if (band_q == 8'h00) begin
                  lim_d = 1'b1;
                end else begin
                  band_d = band_q - 8'd1;
                  dec_d  = 1'b1;
                  reload = 1'b1;
                end
              end
              cnt_d   = '0;
              rail_d  = RAIL_NONE;
              hold_d  = HOLD_LAST;
              state_d = ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          cnt_d  = '0;
          rail_d = RAIL_NONE;
          if (hold_q == '0) begin
            state_d = ST_TRACK;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = ST_TRACK;
      endcase
    end
  end

  // Stage 1 registers: integrator, proportional term and pipeline valid.
  always_ff @(posedge ref_clk or posedge csr_dlf_rst) begin
    if (csr_dlf_rst) begin
      int_acc_q <= INT_MID;
      prop_q    <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      int_acc_q <= int_acc_d;
      if (phe_vld) prop_q <= prop_d;
      s1_vld_q  <= phe_vld;
    end
  end

  // Stage 2 registers: control word and its saturation flags.
  always_ff @(posedge ref_clk or posedge csr_dlf_rst) begin
    if (csr_dlf_rst) begin
      out_q    <= 16'h8000;
      vld_q    <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_q    <= out_d;
        sat_hi_q <= sat_hi_d;
        sat_lo_q <= sat_lo_d;
      end
    end
  end

  // Band tracker state registers.
  always_ff @(posedge ref_clk or posedge csr_dlf_rst) begin
    if (csr_dlf_rst) begin
      state_q <= ST_TRACK;
      rail_q  <= RAIL_NONE;
      cnt_q   <= '0;
      hold_q  <= '0;
      band_q  <= 8'h80;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rail_q  <= rail_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      band_q  <= band_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      lim_q   <= lim_d;
    end
  end

  assign dlf_out  = out_q;
  assign dlf_vld  = vld_q;
  assign sat_hi   = sat_hi_q;
  assign sat_lo   = sat_lo_q;
  assign band     = band_q;
  assign band_inc = inc_q;
  assign band_dec = dec_q;
  assign band_lim = lim_q;

endmodule

// File: tb/tb_flb_dlf.sv
// Bench for flb_dlf: directed scenarios with constant expectations plus a
// randomized run checked cycle by cycle against an arithmetic reference model.
module tb_flb_dlf;

  localparam int HOLDOFF_CYC = 64;
  localparam int PHE_W       = 10;

  logic               ref_clk = 1'b0;
  logic               csr_dlf_rst = 1'b0;
  logic signed [9:0]  phe = '0;
  logic               phe_vld = 1'b0;
  logic [2:0]         kp = '0, ki = '0;
  logic               freeze = 1'b0, int_load = 1'b0;
  logic [15:0]        int_init = '0;
  logic [7:0]         band_init = '0;
  logic               bt_en = 1'b0;
  logic [3:0]         bt_cnt = '0;
  logic [15:0]        dlf_out;
  logic               dlf_vld;
  logic [7:0]         band;
  logic               band_inc, band_dec, sat_hi, sat_lo, band_lim;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ref_clk = ~ref_clk;

  flb_dlf #(.HOLDOFF_CYC(HOLDOFF_CYC), .PHE_W(PHE_W)) dut (
    .ref_clk(ref_clk), .csr_dlf_rst(csr_dlf_rst), .phe(phe), .phe_vld(phe_vld),
    .csr_dlf_kp_shift(kp), .csr_dlf_ki_shift(ki), .csr_dlf_freeze(freeze),
    .csr_dlf_int_load(int_load), .csr_dlf_int_init(int_init), .csr_dlf_band_init(band_init),
    .csr_dlf_bt_en(bt_en), .csr_dlf_bt_cnt(bt_cnt), .dlf_out(dlf_out), .dlf_vld(dlf_vld),
    .band(band), .band_inc(band_inc), .band_dec(band_dec), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .band_lim(band_lim)
  );

  // reference model: plain integer arithmetic on the filter and tracking rules
  int m_int, m_prop, m_out, m_band, m_hold, m_rail, m_run;
  bit m_pend, m_vld, m_shi, m_slo, m_inc, m_dec, m_lim;

  always @(posedge ref_clk or posedge csr_dlf_rst) begin : model
    int o_int, o_prop, s, p;
    bit o_pend, do_reload, hi, lo;
    if (csr_dlf_rst) begin
      m_int = 'h800000; m_prop = 0; m_pend = 0; m_out = 'h8000; m_vld = 0;
      m_shi = 0; m_slo = 0; m_band = 'h80; m_inc = 0; m_dec = 0; m_lim = 0;
      m_hold = 0; m_rail = 0; m_run = 0;
    end else begin
      o_int = m_int; o_prop = m_prop; o_pend = m_pend; do_reload = 0;
      m_vld = o_pend; m_inc = 0; m_dec = 0;
      if (o_pend) begin
        s = (o_int >> 8) + o_prop;
        m_shi = (s > 65535);
        m_slo = (s < 0);
        m_out = (s < 0) ? 0 : ((s > 65535) ? 65535 : s);
      end
      if (int_load) begin
        m_band = band_init; m_lim = 0; m_run = 0; m_rail = 0; m_hold = 0;
      end else if (!bt_en) begin
        m_run = 0; m_rail = 0; m_hold = 0;
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1; m_run = 0; m_rail = 0;
      end else if (o_pend) begin
        hi = ((o_int >> 8) >= 'hF000);
        lo = ((o_int >> 8) <= 'h0FFF);
        if (hi) begin
          m_run = (m_rail == 1) ? ((m_run < 15) ? m_run + 1 : 15) : 1; m_rail = 1;
        end else if (lo) begin
          m_run = (m_rail == -1) ? ((m_run < 15) ? m_run + 1 : 15) : 1; m_rail = -1;
        end else begin
          m_run = 0; m_rail = 0;
        end
        if (m_rail != 0 && bt_cnt != 0 && m_run == int'(bt_cnt)) begin
          if (m_rail == 1) begin
            if (m_band == 255) m_lim = 1;
            else begin m_band = m_band + 1; m_inc = 1; do_reload = 1; end
          end else begin
            if (m_band == 0) m_lim = 1;
            else begin m_band = m_band - 1; m_dec = 1; do_reload = 1; end
          end
          m_run = 0; m_rail = 0; m_hold = HOLDOFF_CYC;
        end
      end
      if (phe_vld) begin
        p = phe;
        m_prop = freeze ? 0 : p * (1 << kp);
        if (!freeze) begin
          s = o_int + p * (1 << ki);
          m_int = (s < 0) ? 0 : ((s > 'hFFFFFF) ? 'hFFFFFF : s);
        end
      end
      if (do_reload) m_int = 'h800000;
      if (int_load) m_int = int'(int_init) * 256;
      m_pend = phe_vld;
    end
  end

  task automatic tick;
    @(posedge ref_clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] init, input logic [7:0] binit);
    int_init = init; band_init = binit; int_load = 1'b1;
    tick;
    int_load = 1'b0;
  endtask

  task automatic pulse_phe(input int v);
    phe = 10'(v); phe_vld = 1'b1;
    tick;
    phe_vld = 1'b0;
  endtask

  task automatic test_reset;
    csr_dlf_rst = 1'b1;
    #12;
    n_tests++;
    if ({dlf_out, band, dlf_vld, band_inc, band_dec, sat_hi, sat_lo, band_lim} !== {16'h8000, 8'h80, 6'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got out=%h band=%h flags=%b, expected out=8000 band=80 flags=000000",
               dlf_out, band, {dlf_vld, band_inc, band_dec, sat_hi, sat_lo, band_lim});
    end
    n_tests++;
    if (dut.int_acc_q !== 24'h800000) begin
      n_fail++; $display("FAIL reset_int_acc: got %h expected 800000", dut.int_acc_q);
    end
    @(negedge ref_clk);
    csr_dlf_rst = 1'b0;
    tick;
  endtask

  task automatic test_prop;
    kp = 3'd2; ki = 3'd0;
    pulse_phe(4);
    n_tests++;
    if (dlf_vld !== 1'b0) begin n_fail++; $display("FAIL prop_early_vld: got %b expected 0", dlf_vld); end
    tick;
    n_tests++;
    if ({dlf_vld, dlf_out} !== {1'b1, 16'h8010}) begin
      n_fail++; $display("FAIL prop_out: got vld=%b out=%h expected vld=1 out=8010", dlf_vld, dlf_out);
    end
    tick;
    n_tests++;
    if (dlf_vld !== 1'b0) begin n_fail++; $display("FAIL prop_vld_pulse: got %b expected 0", dlf_vld); end
    pulse_phe(0);
    tick;
    n_tests++;
    if (dlf_out !== 16'h8000) begin n_fail++; $display("FAIL prop_zero: got %h expected 8000", dlf_out); end
  endtask

  task automatic test_back_to_back;
    int vcount;
    do_load(16'h8000, 8'h80);
    kp = 3'd0; ki = 3'd7;
    phe = 10'sd511; phe_vld = 1'b1; vcount = 0;
    for (int i = 0; i < 4; i++) begin tick; vcount += int'(dlf_vld); end
    phe_vld = 1'b0;
    tick; vcount += int'(dlf_vld);
    n_tests++;
    if (dut.int_acc_q !== 24'h83FE00) begin n_fail++; $display("FAIL int_up: got %h expected 83fe00", dut.int_acc_q); end
    n_tests++;
    if (dlf_out !== 16'h85FD) begin n_fail++; $display("FAIL int_up_out: got %h expected 85fd", dlf_out); end
    tick; vcount += int'(dlf_vld);
    n_tests++;
    if (vcount != 4) begin n_fail++; $display("FAIL b2b_vld_count: got %0d expected 4", vcount); end
    pulse_phe(0);
    tick;
    n_tests++;
    if (dlf_out !== 16'h83FE) begin n_fail++; $display("FAIL int_out_p0: got %h expected 83fe", dlf_out); end
    phe = -10'sd512; phe_vld = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    phe_vld = 1'b0;
    tick;
    n_tests++;
    if (dut.int_acc_q !== 24'h7FFE00) begin n_fail++; $display("FAIL int_down: got %h expected 7ffe00", dut.int_acc_q); end
    n_tests++;
    if (dlf_out !== 16'h7DFE) begin n_fail++; $display("FAIL int_down_out: got %h expected 7dfe", dlf_out); end
  endtask

  task automatic test_saturation;
    kp = 3'd7; ki = 3'd7;
    do_load(16'hFFFF, 8'h80);
    pulse_phe(511);
    n_tests++;
    if (dut.int_acc_q !== 24'hFFFFFF) begin n_fail++; $display("FAIL sat_int_hi: got %h expected ffffff", dut.int_acc_q); end
    tick;
    n_tests++;
    if ({dlf_out, sat_hi, sat_lo} !== {16'hFFFF, 2'b10}) begin
      n_fail++; $display("FAIL sat_hi_out: got out=%h hi=%b lo=%b expected ffff 1 0", dlf_out, sat_hi, sat_lo);
    end
    do_load(16'h0000, 8'h80);
    pulse_phe(-512);
    n_tests++;
    if (dut.int_acc_q !== 24'h000000) begin n_fail++; $display("FAIL sat_int_lo: got %h expected 000000", dut.int_acc_q); end
    tick;
    n_tests++;
    if ({dlf_out, sat_hi, sat_lo} !== {16'h0000, 2'b01}) begin
      n_fail++; $display("FAIL sat_lo_out: got out=%h hi=%b lo=%b expected 0000 0 1", dlf_out, sat_hi, sat_lo);
    end
  endtask

  task automatic test_band_step;
    int bad;
    kp = 3'd0; ki = 3'd0; bt_en = 1'b1; bt_cnt = 4'd3;
    do_load(16'hF800, 8'h80);
    phe = '0; phe_vld = 1'b1;
    tick; tick; tick;
    phe_vld = 1'b0;
    n_tests++;
    if ({band, band_inc} !== {8'h80, 1'b0}) begin
      n_fail++; $display("FAIL step_early: got band=%h inc=%b expected 80 0", band, band_inc);
    end
    tick;
    n_tests++;
    if ({band, band_inc, dlf_vld, dlf_out} !== {8'h81, 1'b1, 1'b1, 16'hF800}) begin
      n_fail++; $display("FAIL step_inc: got band=%h inc=%b vld=%b out=%h expected 81 1 1 f800",
                         band, band_inc, dlf_vld, dlf_out);
    end
    tick;
    n_tests++;
    if (band_inc !== 1'b0) begin n_fail++; $display("FAIL step_pulse: got %b expected 0", band_inc); end
    pulse_phe(0);
    tick;
    n_tests++;
    if (dlf_out !== 16'h8000) begin n_fail++; $display("FAIL step_reload_out: got %h expected 8000", dlf_out); end
    ki = 3'd7; phe = 10'sd511; phe_vld = 1'b1; bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (band !== 8'h81 || band_inc !== 1'b0) bad++;
    end
    phe_vld = 1'b0;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL holdoff_no_step: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_band_limit;
    kp = 3'd0; ki = 3'd0; bt_en = 1'b1; bt_cnt = 4'd2;
    do_load(16'h0800, 8'h00);
    phe = '0; phe_vld = 1'b1;
    tick; tick;
    phe_vld = 1'b0;
    tick;
    n_tests++;
    if ({band, band_lim, band_dec} !== {8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL limit_flags: got band=%h lim=%b dec=%b expected 00 1 0", band, band_lim, band_dec);
    end
    n_tests++;
    if (dut.int_acc_q !== 24'h080000) begin n_fail++; $display("FAIL limit_int: got %h expected 080000", dut.int_acc_q); end
    do_load(16'h8000, 8'h80);
    n_tests++;
    if ({band_lim, band} !== {1'b0, 8'h80}) begin
      n_fail++; $display("FAIL limit_clear: got lim=%b band=%h expected 0 80", band_lim, band);
    end
    bt_en = 1'b0;
  endtask

  task automatic test_freeze_reset;
    bt_en = 1'b0; kp = 3'd3; ki = 3'd0;
    do_load(16'h1234, 8'h80);
    freeze = 1'b1; phe = 10'sd100; phe_vld = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_tests++;
      if ({dlf_vld, dlf_out} !== {1'b1, 16'h1234}) begin
        n_fail++; $display("FAIL freeze_hold: got vld=%b out=%h expected 1 1234", dlf_vld, dlf_out);
      end
    end
    phe_vld = 1'b0;
    tick; tick;
    freeze = 1'b0;
    pulse_phe(100);
    #1 csr_dlf_rst = 1'b1;
    #1;
    n_tests++;
    if ({dlf_out, band, dlf_vld, band_inc, band_dec, sat_hi, sat_lo, band_lim} !== {16'h8000, 8'h80, 6'b0}
        || dut.int_acc_q !== 24'h800000) begin
      n_fail++; $display("FAIL midrst_outputs: got out=%h band=%h int=%h expected 8000 80 800000",
                         dlf_out, band, dut.int_acc_q);
    end
    @(negedge ref_clk);
    csr_dlf_rst = 1'b0;
    tick;
    n_tests++;
    if ({dlf_vld, dlf_out} !== {1'b0, 16'h8000}) begin
      n_fail++; $display("FAIL midrst_no_vld: got vld=%b out=%h expected 0 8000", dlf_vld, dlf_out);
    end
  endtask

  task automatic test_random;
    logic [53:0] exp_v, got_v;
    logic [15:0] rinit;
    for (int seg = 0; seg < 8; seg++) begin
      kp = 3'($urandom_range(0, 7)); ki = 3'($urandom_range(0, 3));
      bt_en = ($urandom_range(0, 4) != 0); bt_cnt = 4'($urandom_range(0, 15)); freeze = 1'b0;
      case ($urandom_range(0, 2))
        0: rinit = 16'($urandom_range(0, 'h0FFF));
        1: rinit = 16'($urandom_range('hF000, 'hFFFF));
        default: rinit = 16'($urandom_range(0, 'hFFFF));
      endcase
      case ($urandom_range(0, 3))
        0: do_load(rinit, 8'h00);
        1: do_load(rinit, 8'hFF);
        2: do_load(rinit, 8'h01);
        default: do_load(rinit, 8'($urandom_range(0, 255)));
      endcase
      for (int c = 0; c < 300; c++) begin
        phe_vld  = ($urandom_range(0, 9) < 7);
        phe      = 10'($urandom_range(0, 1023));
        freeze   = ($urandom_range(0, 19) == 0);
        int_load = ($urandom_range(0, 99) == 0);
        int_init = ($urandom_range(0, 1) == 0) ? 16'($urandom_range('hF000, 'hFFFF))
                                                : 16'($urandom_range(0, 'h0FFF));
        band_init = 8'($urandom_range(0, 255));
        tick;
        exp_v = {24'(m_int), 16'(m_out), m_vld, 8'(m_band), m_inc, m_dec, m_shi, m_slo, m_lim};
        got_v = {dut.int_acc_q, dlf_out, dlf_vld, band, band_inc, band_dec, sat_hi, sat_lo, band_lim};
        n_tests++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL random seg%0d cyc%0d: got %h expected %h", seg, c, got_v, exp_v);
        end
        if ($urandom_range(0, 199) == 0) csr_dlf_rst = 1'b1;
        else csr_dlf_rst = 1'b0;
      end
      csr_dlf_rst = 1'b0; phe_vld = 1'b0; int_load = 1'b0; freeze = 1'b0;
      tick; tick;
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_prop;
    test_back_to_back;
    test_saturation;
    test_band_step;
    test_band_limit;
    test_freeze_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
